// File: rtl/dl_rr_arbiter.sv
// dl_rr_arbiter
// Round-robin merge of NUM_REQ valid/ready requesters into one registered
// output stage. The winner's payload and index are captured on the clock
// edge after the grant; a full output register is refilled in the same cycle
// the downstream accepts it, so back-to-back transfers carry no bubble.
//
// Optional feature macro: DL_ARB_LOCK_EN
//   When defined, the req_lock port exists and a transfer from a locked
//   requester keeps the priority pointer on that requester.
//
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset
//   req_valid  per-requester valid
//   req_data   payloads, requester i at [i*DATA_W +: DATA_W]
//   req_ready  per-requester ready, one-hot or zero
//   out_valid  output register holds an entry
//   out_data   registered payload
//   out_src    index of the requester that supplied out_data
//   out_ready  downstream accepts the entry
//   req_lock   (DL_ARB_LOCK_EN only) hold priority on the granted requester
module dl_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready
`ifdef DL_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]        req_lock
`endif
);

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [SRC_W-1:0]    r_out_src;
  logic [SRC_W-1:0]    r_ptr;

  logic [DATA_W-1:0]   w_req_arr [NUM_REQ];
  logic                w_load;
  logic                w_found;
  logic                w_xfer;
  logic [SRC_W-1:0]    w_gnt_idx;
  logic [DATA_W-1:0]   w_gnt_data;
  logic [SRC_W:0]      w_sum;
  logic [SRC_W-1:0]    w_scan;
  logic [SRC_W-1:0]    w_ptr_inc;
  logic [SRC_W-1:0]    w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_req_ready;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  assign w_load = !r_out_valid || out_ready;

  // Scan from r_ptr upward with wrap; first asserted request wins.
  always_comb begin
    w_found    = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    w_sum      = '0;
    w_scan     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (SRC_W+1)'(k);
      if (w_sum >= (SRC_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (SRC_W+1)'(NUM_REQ);
      end
      w_scan = w_sum[SRC_W-1:0];
      if (!w_found && req_valid[w_scan]) begin
        w_found    = 1'b1;
        w_gnt_idx  = w_scan;
        w_gnt_data = w_req_arr[w_scan];
      end
    end
  end

  // rst gates ready so no requester sees a handshake while the stage is held in reset.
  assign w_xfer = w_found && w_load && !rst;

  always_comb begin
    w_req_ready = '0;
    if (w_xfer) begin
      w_req_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign req_ready = w_req_ready;

  always_comb begin
    if (w_gnt_idx == SRC_W'(NUM_REQ-1)) begin
      w_ptr_inc = '0;
    end else begin
      w_ptr_inc = w_gnt_idx + SRC_W'(1);
    end
    w_ptr_nxt = w_ptr_inc;
`ifdef DL_ARB_LOCK_EN
    if (req_lock[w_gnt_idx]) begin
      w_ptr_nxt = w_gnt_idx;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_src   <= w_gnt_idx;
        r_ptr       <= w_ptr_nxt;
      end else begin
        // Drained with nothing pending: payload and source are left as-is.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_dl_rr_arbiter.sv
module tb_dl_rr_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_ready;
`ifdef DL_ARB_LOCK_EN
  logic [3:0]   req_lock;
`endif

  typedef struct {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  dl_rr_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef DL_ARB_LOCK_EN
    ,
    .req_lock  (req_lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] base);
    req_data = {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic exp_t mk(input logic [1:0] s, input logic [31:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst       = 1'b1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    set_data(32'hA0);
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_src !== 2'd0 || out_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b src=%0d data=%h, want 0 0 0", out_valid, out_src, out_data);
    end
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_ready: got %b want 0001", req_ready);
    end
    sb.push_back(mk(2'd0, 32'hA0));
    tick();
    e = sb.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
      n_err++;
      $display("FAIL reset_first_grant: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
    end
  endtask

  task automatic test_full_contention();
    exp_t e;
    do_reset();
    req_valid = 4'hF;
    out_ready = 1'b1;
    set_data(32'hA0);
    sb.push_back(mk(2'd0, 32'hA0));
    sb.push_back(mk(2'd1, 32'hA1));
    sb.push_back(mk(2'd2, 32'hA2));
    sb.push_back(mk(2'd3, 32'hA3));
    sb.push_back(mk(2'd0, 32'hA0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
        n_err++;
        $display("FAIL contention: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
      end
    end
  endtask

  // Entering with out=(0,A0) held valid and ptr=1.
  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hA0 || req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL backpressure_hold: v=%b src=%0d data=%h rdy=%b want 1 0 a0 0000", out_valid, out_src, out_data, req_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL backpressure_release_ready: got %b want 0010", req_ready);
    end
    sb.push_back(mk(2'd1, 32'hA1));
    tick();
    e = sb.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
      n_err++;
      $display("FAIL backpressure_refill: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
    end
  endtask

  // Entering with ptr=2.
  task automatic test_sparse_wrap();
    exp_t e;
    set_data(32'hB0);
    out_ready = 1'b1;
    req_valid = 4'b0100;
    sb.push_back(mk(2'd2, 32'hB2));
    tick();
    e = sb.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
      n_err++;
      $display("FAIL sparse_setup: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
    end
    req_valid = 4'b0101;
    sb.push_back(mk(2'd0, 32'hB0));
    sb.push_back(mk(2'd2, 32'hB2));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
        n_err++;
        $display("FAIL sparse_wrap: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
      end
    end
    req_valid = 4'b0000;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_src !== 2'd2 || out_data !== 32'hB2) begin
      n_err++;
      $display("FAIL idle_drain: v=%b src=%0d data=%h want 0 2 b2", out_valid, out_src, out_data);
    end
    req_valid = 4'hF;
    #1;
    n_vec++;
    if (req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL idle_ptr_hold: ready=%b want 1000", req_ready);
    end
    sb.push_back(mk(2'd3, 32'hB3));
    tick();
    e = sb.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
      n_err++;
      $display("FAIL idle_resume: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
    end
  endtask

`ifdef DL_ARB_LOCK_EN
  task automatic test_lock();
    exp_t e;
    req_lock  = 4'b0010;
    req_valid = 4'b1010;
    out_ready = 1'b1;
    set_data(32'hC0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(2'd1, 32'hC1));
    end
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
        n_err++;
        $display("FAIL lock_hold: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
      end
    end
    req_lock = 4'b0000;
    sb.push_back(mk(2'd1, 32'hC1));
    sb.push_back(mk(2'd3, 32'hC3));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
        n_err++;
        $display("FAIL lock_release: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
      end
    end
  endtask
`endif

  task automatic test_mid_reset();
    exp_t e;
    set_data(32'hD0);
    req_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_setup: v=%b want 1", out_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_src !== 2'd0 || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset_async: v=%b data=%h src=%0d rdy=%b want 0 0 0 0000", out_valid, out_data, out_src, req_ready);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_reset_ptr: ready=%b want 0001", req_ready);
    end
    sb.push_back(mk(2'd0, 32'hD0));
    tick();
    e = sb.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
      n_err++;
      $display("FAIL mid_reset_regrant: v=%b src=%0d data=%h want 1 %0d %h", out_valid, out_src, out_data, e.src, e.data);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
`ifdef DL_ARB_LOCK_EN
    req_lock  = '0;
`endif
    test_reset();
    test_full_contention();
    test_backpressure();
    test_sparse_wrap();
`ifdef DL_ARB_LOCK_EN
    test_lock();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dl_rr_arbiter.md
# dl_rr_arbiter

Round-robin arbiter that shares one registered output stage, a bank of DATA_W D flip-flops plus a valid bit, between NUM_REQ requesters. Each requester presents data with a valid/ready handshake. The arbiter grants at most one requester per cycle, captures the winner's data and source index into the output register, and presents it downstream with its own valid/ready handshake. It sits at merge points in the core, for example several producers feeding one writeback or memory-request path.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters; must be ≥2.
- DATA_W, default 32: payload width.
- SRC_W, default $clog2(NUM_REQ): width of the source index.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester ready; one-hot or zero.
- out_valid  output  1  output register holds a valid entry.
- out_data  output  DATA_W  registered payload.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts the entry.
- req_lock  input  NUM_REQ  present only with DL_ARB_LOCK_EN; see Configuration.

## Operation
- State:
  - output register (out_valid, out_data, out_src);
  - priority pointer ptr (SRC_W bits, range 0..NUM_REQ-1).
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0. While rst=1, req_ready=0.
- load = !out_valid || out_ready. The output register may accept new data only when load=1.
- Grant selection (combinational):
  - Scan req_valid starting at index ptr, ascending, wrapping NUM_REQ-1 → 0.
  - The first asserted index g wins.
  - req_ready[g] = load && !rst; all other req_ready bits are 0.
- Transfer from g (req_valid[g] && req_ready[g]) at posedge:
  - out_valid←1, out_data←req_data[g], out_src←g;
  - ptr←(g+1) mod NUM_REQ.
- load=1 with no req_valid: out_valid←0; ptr unchanged; out_data and out_src hold their last values.
- load=0 (out_valid=1, out_ready=0): output register and ptr hold; all req_ready=0.
- Simultaneous downstream accept and upstream grant (out_valid=1, out_ready=1, a request present) refills the register in the same cycle, with no bubble.
- req_ready depends combinationally on req_valid and out_ready. Requesters must not derive req_valid from req_ready.
- Asynchronous reset during any state drops the held entry immediately: out_valid=0, ptr=0. Nothing is replayed after reset.

## Timing
- Latency: req→out is 1 cycle. Data accepted at edge k is visible on out_* after edge k.
- Throughput: 1 transfer per cycle while out_ready=1.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once in any NUM_REQ consecutive transfers.
- out_data and out_src are stable while out_valid=1 and out_ready=0.
- There is no combinational path from req_data to out_data.

## Configuration
- Macro: DL_ARB_LOCK_EN.
- Defined:
  - The req_lock port exists.
  - On a transfer from g with req_lock[g]=1, ptr←g instead of g+1, so g keeps top priority on the next grant.
  - If g is idle, the other requesters are still granted in the normal scan order, so there is no deadlock.
  - A transfer from g with req_lock[g]=0 resumes normal rotation.
- Undefined: the req_lock port is absent and ptr always advances to g+1.

## Test plan
All scenarios use NUM_REQ=4, DATA_W=32.

1. Reset: assert rst with all req_valid=1 → out_valid=0, out_src=0, req_ready=0 while rst=1. After release, the first grant goes to requester 0.
2. Full contention: all req_valid=1, req_data=0xA0,0xA1,0xA2,0xA3, out_ready=1 → out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0, no bubbles.
3. Backpressure: out_valid=1, out_ready=0 held for 3 cycles → out_data and out_src unchanged, req_ready=0000. When out_ready rises with requests pending, a new entry loads on the same edge.
4. Sparse/wrap: ptr=3, only req_valid[0] and req_valid[2] set → grants 0 then 2. With no requests and out_ready=1 → out_valid falls to 0 and ptr is unchanged.
5. Lock (DL_ARB_LOCK_EN): req_valid[1]=req_valid[3]=1, req_lock[1]=1 for 3 transfers → out_src 1,1,1. Drop req_lock[1] → out_src 1 then 3.
6. Mid-transfer reset: assert rst asynchronously while out_valid=1 and out_ready=0 → out_valid drops before the next clock edge; ptr=0 after release.
